// File: rtl/axi_pkg.sv
// Shared AXI constants and the read-master state encoding.
package axi_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_READ, RD_DONE} rd_state_e;
endpackage

// File: rtl/axi_master_ifm_rd_if.sv
// AXI4 read-address and read-data channels between the IFM read master and the interconnect.
interface axi_master_ifm_rd_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 128
);
  logic [AXI_ADDR_W-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_master_ifm_rd.sv
// Fetches one IFM tile as a single INCR burst and streams every R beat into the IFM buffer.
module axi_master_ifm_rd
  import axi_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 128,
  parameter int BUF_ADDR_W = 10,
  parameter int BURST_LEN  = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_read,
  input  logic [AXI_ADDR_W-1:0] base_addr,
  output logic                  done,
  output logic                  error,
  axi_master_ifm_rd_if.master   axi,
  output logic                  wr_en,
  output logic [BUF_ADDR_W-1:0] wr_addr,
  output logic [AXI_DATA_W-1:0] wr_data
);
  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LEN_C     = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(BURST_LEN - 1);
  localparam logic [7:0]       ARLEN_C   = 8'(BURST_LEN - 1);
  localparam logic [2:0]       ARSIZE_C  = 3'($clog2(AXI_DATA_W / 8));

  rd_state_e             state_q, state_d;
  logic                  start_read_q;
  logic                  done_q, done_d, error_q, error_d;
  logic [AXI_ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;
  logic                  arvalid_q, arvalid_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;
  logic                  wr_en_q, wr_en_d;
  logic [BUF_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [AXI_DATA_W-1:0] wr_data_q, wr_data_d;

  logic start_pulse, r_fire, launch;
  assign start_pulse = start_read & ~start_read_q;
  assign launch      = (state_q == RD_IDLE) & start_pulse;
  assign r_fire      = axi.rvalid & axi.rready;

  // FSM; done/error are registered so they land one cycle after DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE: if (start_pulse)                state_d = RD_ADDR;
      RD_ADDR: if (arvalid_q && axi.arready)   state_d = RD_READ;
      RD_READ: if (r_fire && axi.rlast)        state_d = RD_DONE;
      RD_DONE:                                 state_d = RD_IDLE;
      default:                                 state_d = RD_IDLE;
    endcase
    done_d  = (state_q == RD_DONE);
    error_d = (state_q == RD_DONE) & err_q;
  end

  always_comb begin
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    arvalid_d = arvalid_q;
    if (launch) begin
      araddr_d  = base_addr;
      arlen_d   = ARLEN_C;
      arsize_d  = ARSIZE_C;
      arburst_d = AXI_BURST_INCR;
      arvalid_d = 1'b1;
    end else if (state_q == RD_ADDR && axi.arready) begin
      arvalid_d = 1'b0;
    end
  end

  // Beat counter saturates so a runaway burst can never wrap back onto low buffer addresses
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    if (launch) begin
      beat_cnt_d = '0;
      err_d      = 1'b0;
    end else if (r_fire) begin
      beat_cnt_d = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + CNT_W'(1);
      if (axi.rresp != AXI_RESP_OKAY || (axi.rlast && beat_cnt_q != LAST_C))
        err_d = 1'b1;
    end
  end

  always_comb begin
    wr_en_d   = r_fire && (beat_cnt_q < LEN_C);
    wr_addr_d = r_fire ? BUF_ADDR_W'(beat_cnt_q) : wr_addr_q;
    wr_data_d = r_fire ? axi.rdata : wr_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RD_IDLE;
      start_read_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      arvalid_q    <= 1'b0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      start_read_q <= start_read;
      done_q       <= done_d;
      error_q      <= error_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      arvalid_q    <= arvalid_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = arburst_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = (state_q == RD_READ);
  assign done        = done_q;
  assign error       = error_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
endmodule

// File: tb/tb_axi_master_ifm_rd.sv
// Bench for the IFM read master: transaction-level model checked every cycle plus directed literal checks.
module tb_axi_master_ifm_rd;
  localparam int AW = 32, DW = 128, BW = 10, BL = 128;

  logic          clk = 1'b0, rst_n = 1'b0, start_read = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          done, error, wr_en;
  logic [BW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  axi_master_ifm_rd_if #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW)) axi ();

  axi_master_ifm_rd #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .BUF_ADDR_W(BW), .BURST_LEN(BL)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_read(start_read), .base_addr(base_addr),
    .done(done), .error(error), .axi(axi.master),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else passed++;
  endtask

  // Model: phase 0 idle, 1 address, 2 data, 3 closing cycle
  int            ph = 0, m_beats = 0, cyc = 0;
  logic          m_arvalid = 0, m_rready = 0, m_wr = 0, m_done = 0, m_err = 0, m_start_prev = 0;
  logic          wr_n, done_n, sp;
  logic [AW-1:0] m_base = '0;
  logic [BW-1:0] m_wa = '0;
  logic [DW-1:0] m_wd = '0;
  int            n_wr = 0, n_done = 0;
  logic          last_err = 0;
  logic [BW-1:0] last_wa = '0;
  logic [DW-1:0] last_wd = '0;
  logic [AW-1:0] cap_addr = '0;
  logic [7:0]    cap_len = '0;
  logic [2:0]    cap_size = '0;
  logic [1:0]    cap_burst = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_ctrl", DW'({done, error, wr_en, axi.arvalid, axi.rready}), '0);
      chk("rst_ar", DW'({axi.araddr, axi.arlen, axi.arsize, axi.arburst}), '0);
      chk("rst_wr", DW'(wr_addr) | wr_data, '0);
      ph = 0; m_beats = 0; m_arvalid = 0; m_rready = 0; m_wr = 0; m_done = 0; m_err = 0;
      m_start_prev = 0;
    end else begin
      chk("arvalid", DW'(axi.arvalid), DW'(m_arvalid));
      if (m_arvalid) chk("araddr", DW'(axi.araddr), DW'(m_base));
      chk("rready", DW'(axi.rready), DW'(m_rready));
      chk("wr_en", DW'(wr_en), DW'(m_wr));
      if (m_wr) begin
        chk("wr_addr", DW'(wr_addr), DW'(m_wa));
        chk("wr_data", wr_data, m_wd);
      end
      chk("done", DW'(done), DW'(m_done));
      chk("error", DW'(error), DW'(m_done & m_err));
      if (wr_en) begin n_wr++; last_wa = wr_addr; last_wd = wr_data; end
      if (done) begin n_done++; last_err = error; end
      if (axi.arvalid) begin
        cap_addr = axi.araddr; cap_len = axi.arlen; cap_size = axi.arsize; cap_burst = axi.arburst;
      end
      sp = start_read && !m_start_prev;
      m_start_prev = start_read;
      wr_n = 0;
      done_n = (ph == 3);
      case (ph)
        0: if (sp) begin ph = 1; m_base = base_addr; m_beats = 0; m_err = 0; end
        1: if (axi.arready) ph = 2;
        2: if (axi.rvalid) begin
             if (m_beats < BL) begin wr_n = 1; m_wa = BW'(m_beats); m_wd = axi.rdata; end
             if (axi.rresp != 2'b00) m_err = 1;
             if (axi.rlast) begin
               if (m_beats != BL - 1) m_err = 1;
               ph = 3;
             end
             m_beats++;
           end
        default: ph = 0;
      endcase
      m_arvalid = (ph == 1);
      m_rready  = (ph == 2);
      m_wr      = wr_n;
      m_done    = done_n;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One transfer as the AXI slave; rst_at >= 0 aborts with a reset before that beat
  task automatic run_burst(input logic [AW-1:0] base, input int nbeats, input int last_beat,
                           input int slv_beat, input bit bp, input int rst_at, input bit glitch,
                           input logic [31:0] dseed);
    bit ok = 0, fire, glitched = 0, v;
    int i = 0, guard = 0;
    base_addr = base;
    start_read = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (axi.arvalid) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin chk("ar_timeout", 1, 0); return; end
    tick(); tick();
    axi.arready = 1;
    tick();
    axi.arready = 0;
    if (!glitch) start_read = 0;
    while (i < nbeats && guard < 5000) begin
      if (i == rst_at) begin
        axi.rvalid = 0; start_read = 0; rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
        return;
      end
      if (glitch && i == 50 && !glitched) begin
        axi.rvalid = 0; start_read = 0;
        tick();
        start_read = 1; glitched = 1;
      end
      v = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.rvalid = v;
      axi.rdata  = {96'(dseed), 32'(i)};
      axi.rresp  = (i == slv_beat) ? 2'b10 : 2'b00;
      axi.rlast  = (i == last_beat);
      @(negedge clk);
      fire = v && axi.rready;
      tick();
      if (fire) i++;
      guard++;
    end
    if (guard >= 5000) chk("r_timeout", 1, 0);
    axi.rvalid = 0; axi.rlast = 0; axi.rresp = 0;
    repeat (4) tick();
  endtask

  int w0, d0, t0;

  initial begin
    axi.arready = 0; axi.rvalid = 0; axi.rlast = 0; axi.rresp = 0; axi.rdata = '0;
    tick(); tick();
    rst_n = 1;
    tick();

    // Nominal
    w0 = n_wr; d0 = n_done;
    run_burst(32'h1000_0000, 128, 127, -1, 0, -1, 0, 0);
    chk("nom_araddr", DW'(cap_addr), DW'(32'h1000_0000));
    chk("nom_arlen", DW'(cap_len), DW'(127));
    chk("nom_arsize", DW'(cap_size), DW'(4));
    chk("nom_arburst", DW'(cap_burst), DW'(1));
    chk("nom_writes", DW'(n_wr - w0), DW'(128));
    chk("nom_last_addr", DW'(last_wa), DW'(127));
    chk("nom_last_data", last_wd, DW'(127));
    chk("nom_dones", DW'(n_done - d0), DW'(1));
    chk("nom_error", DW'(last_err), DW'(0));

    // R backpressure
    w0 = n_wr; d0 = n_done;
    run_burst(32'h2000_0400, 128, 127, -1, 1, -1, 0, 32'h5A5A);
    chk("bp_writes", DW'(n_wr - w0), DW'(128));
    chk("bp_last_data", last_wd, {96'(32'h5A5A), 32'd127});
    chk("bp_dones", DW'(n_done - d0), DW'(1));
    chk("bp_error", DW'(last_err), DW'(0));

    // SLVERR on beat 40
    w0 = n_wr;
    run_burst(32'h3000_0000, 128, 127, 40, 0, -1, 0, 1);
    chk("slv_writes", DW'(n_wr - w0), DW'(128));
    chk("slv_error", DW'(last_err), DW'(1));

    // Early rlast on beat 99, then a clean transfer
    w0 = n_wr;
    run_burst(32'h4000_0000, 100, 99, -1, 0, -1, 0, 2);
    chk("early_writes", DW'(n_wr - w0), DW'(100));
    chk("early_last_addr", DW'(last_wa), DW'(99));
    chk("early_error", DW'(last_err), DW'(1));
    w0 = n_wr;
    run_burst(32'h4000_8000, 128, 127, -1, 0, -1, 0, 3);
    chk("clean_writes", DW'(n_wr - w0), DW'(128));
    chk("clean_error", DW'(last_err), DW'(0));

    // start_read held high with a re-raise mid-burst
    w0 = n_wr; d0 = n_done; t0 = cyc;
    run_burst(32'h5000_0000, 128, 127, -1, 0, -1, 1, 4);
    while (cyc - t0 < 500) tick();
    start_read = 0;
    repeat (3) tick();
    chk("hold_writes", DW'(n_wr - w0), DW'(128));
    chk("hold_dones", DW'(n_done - d0), DW'(1));

    // Reset before beat 64: 64 beats fire but the last write is wiped by the async reset
    w0 = n_wr; d0 = n_done;
    run_burst(32'h6000_0000, 128, 127, -1, 0, 64, 0, 5);
    chk("rst_writes", DW'(n_wr - w0), DW'(63));
    chk("rst_dones", DW'(n_done - d0), DW'(0));
    w0 = n_wr;
    run_burst(32'h6000_1000, 128, 127, -1, 0, -1, 0, 6);
    chk("post_rst_writes", DW'(n_wr - w0), DW'(128));
    chk("post_rst_error", DW'(last_err), DW'(0));
    chk("post_rst_araddr", DW'(cap_addr), DW'(32'h6000_1000));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
